ipv4_hdr_parse: RTL and testbench
=================================

IPV4_HDR_PARSE -- requirements
Module: ipv4_hdr_parse

Interface
REQ-001 SHALL have parameter CHK_EN, default 1, meaning 1 = verify header checksum and 0 = ignore it.
REQ-002 SHALL have parameter ACCEPT_BCAST, default 1, meaning 1 = also accept des IP 32'hFFFFFFFF.
REQ-003 rx_clk  in  1  sole clock; one clock, all logic on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 ip_pkt_start  in  1  single-cycle pulse coincident with the first ip_pkt_en byte (first byte after EtherType).
REQ-006 ip_pkt_en  in  1  ip_pkt_dat valid.
REQ-007 ip_pkt_dat  in  8  frame byte after EtherType, network order.
REQ-008 ip_pkt_end  in  1  pulse coincident with the last ip_pkt_en byte (may include Ethernet pad).
REQ-009 ip_prot_type  in  16  EtherType; stable from ip_pkt_start to ip_pkt_end.
REQ-010 local_ip_addr  in  32  own IP; quasi-static.
REQ-011 src_ip_addr, des_ip_addr  out  32 each  addresses of the last accepted header.
REQ-012 trans_prot_type  out  8  protocol field of the last accepted header.
REQ-013 trans_pkt_start / trans_pkt_en / trans_pkt_end  out  1 each  payload framing.
REQ-014 trans_pkt_dat  out  8  payload byte.
REQ-015 trans_pkt_err  out  1  pulse with trans_pkt_end when the payload was truncated or aborted.
REQ-016 hdr_err  out  1  single-cycle pulse on a rejected header.

Function
REQ-017 SHALL use states IDLE, HDR, PAYLOAD, DROP.
REQ-018 IDLE -> HDR on ip_pkt_start && ip_prot_type==16'h0800; start with any other EtherType -> DROP, no hdr_err.
REQ-019 HDR SHALL count header bytes with a 6-bit counter, including the start byte, and capture:
  - version/IHL (byte 0)
  - total_len (bytes 2-3)
  - flags/frag offset (bytes 6-7)
  - protocol (byte 9)
  - src IP (12-15), des IP (16-19)
  - skip options up to IHL*4 bytes.
REQ-020 Checksum SHALL be a ones-complement sum of header 16-bit words including the checksum field, with end-around carry; it passes iff the final value is 16'hFFFF.
REQ-021 Header check SHALL run at the last header byte (byte IHL*4-1). Accept iff all of:
  - version==4
  - IHL>=5
  - total_len >= IHL*4
  - MF==0 and frag offset==0
  - checksum passes (if CHK_EN)
  - des IP == local_ip_addr, or ==32'hFFFFFFFF with ACCEPT_BCAST.
REQ-022 On accept, src_ip_addr/des_ip_addr/trans_prot_type SHALL update on the same edge. State goes to PAYLOAD, or to DROP if payload length is 0, with no trans outputs.
REQ-023 On reject: hdr_err pulses one cycle after the last header byte; state -> DROP; registered address outputs are unchanged.
REQ-024 Payload length SHALL be total_len - IHL*4 (16-bit). Bytes beyond it (pad) are discarded.
REQ-025 trans_pkt_en/dat SHALL be registered: one cycle latency from ip_pkt_en/dat.
REQ-026 trans_pkt_start SHALL be asserted with the first payload byte, and trans_pkt_end with the byte numbered payload length. Payload length 1 gives start and end in the same cycle.
REQ-027 After the last payload byte: PAYLOAD -> DROP, or -> IDLE if ip_pkt_end is in the same cycle.
REQ-028 DROP -> IDLE on ip_pkt_end.
REQ-029 ip_pkt_end in HDR SHALL give hdr_err and go to IDLE.
REQ-030 ip_pkt_end in PAYLOAD before the length is reached SHALL output the final byte with trans_pkt_end=1 and trans_pkt_err=1.
REQ-031 ip_pkt_start in any non-IDLE state SHALL abort the current packet and restart HDR with that byte. If the aborted packet was in PAYLOAD, one cycle of trans_pkt_end=1, trans_pkt_err=1, trans_pkt_en=0 is emitted.
REQ-032 Cycles with ip_pkt_en=0 SHALL be ignored; counters hold.

Reset
REQ-033 While rst_n=0: state=IDLE; all counters 0; checksum accumulator 0.
REQ-034 Output reset values: all 1-bit outputs 0; trans_pkt_dat 8'h00; src_ip_addr, des_ip_addr 32'h0; trans_prot_type 8'h0.
REQ-035 Reset mid-packet SHALL discard the packet. The first packet after rst_n rises SHALL be parsed only from its ip_pkt_start.

Structure
REQ-036 Shared package tcpip_pkg SHALL hold:
  - ETH_TYPE_IPV4 = 16'h0800
  - IP_PROT_UDP = 8'd17
  - IP_PROT_TCP = 8'd6
  - IPV4_MIN_IHL = 5
  - the parser state enum.
REQ-037 SHALL instantiate one sub-module, ip_csum16: a byte-fed ones-complement accumulator with clear, enable and a sum output.

Verification
REQ-038 Valid UDP: 28-byte IPv4 header with correct checksum, total_len=48, des IP=local 32'hC0A800AE, 20-byte payload 8'h00..8'h13 -> start with 8'h00, 20 en cycles, end with 8'h13, trans_prot_type=8'd17, no err.
REQ-039 Same header with one checksum bit flipped, CHK_EN=1 -> hdr_err pulse, no trans outputs, src_ip_addr unchanged. With CHK_EN=0 -> accepted.
REQ-040 total_len=46 on a 64-byte frame (pad present) -> exactly 26 payload bytes out, end on byte 26, pad dropped.
REQ-041 des IP 32'hC0A800AF; also MF=1; also EtherType 16'h0806 -> no trans outputs. hdr_err only for the first two cases.
REQ-042 ip_pkt_start after 5 payload bytes, en gaps inserted -> 5 bytes out, then end+err pulse, then second packet parsed correctly.
REQ-043 rst_n low for 2 cycles mid-payload -> all outputs at reset values; the next valid packet is accepted normally.

Source files
------------

// File: rtl/tcpip_pkg.sv
// Shared TCP/IP stack constants, parser state encoding and
// the ones-complement add used by the header checksum.
package tcpip_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROT_UDP   = 8'd17;
    localparam logic [7:0]  IP_PROT_TCP   = 8'd6;
    localparam logic [3:0]  IPV4_MIN_IHL  = 4'd5;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        DROP
    } ip_parse_state_t;

    // A full carry can never reappear after one fold.
    function automatic logic [15:0] csum_add(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/ip_csum16.sv
// Byte-fed ones-complement accumulator; even bytes land in the
// high half of each 16-bit word, odd bytes in the low half.
module ip_csum16
    import tcpip_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  dat,
    output logic [15:0] sum
);

    logic        odd;
    logic        odd_base;
    logic [15:0] base;
    logic [15:0] word;

    always_comb begin
        base     = clr ? 16'h0000 : sum;
        odd_base = clr ? 1'b0 : odd;
        word     = odd_base ? {8'h00, dat} : {dat, 8'h00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 16'h0000;
            odd <= 1'b0;
        end else if (en) begin
            sum <= csum_add(base, word);
            odd <= !odd_base;
        end else if (clr) begin
            sum <= 16'h0000;
            odd <= 1'b0;
        end
    end

endmodule

// File: rtl/ipv4_hdr_parse.sv
// IPv4 header parser: validates the header of each frame and
// forwards the payload, trimmed to total_len, one cycle later.
module ipv4_hdr_parse
    import tcpip_pkg::*;
#(
    parameter bit CHK_EN       = 1'b1,
    parameter bit ACCEPT_BCAST = 1'b1
) (
    input  logic        rx_clk,
    input  logic        rst_n,
    input  logic        ip_pkt_start,
    input  logic        ip_pkt_en,
    input  logic [7:0]  ip_pkt_dat,
    input  logic        ip_pkt_end,
    input  logic [15:0] ip_prot_type,
    input  logic [31:0] local_ip_addr,
    output logic [31:0] src_ip_addr,
    output logic [31:0] des_ip_addr,
    output logic [7:0]  trans_prot_type,
    output logic        trans_pkt_start,
    output logic        trans_pkt_en,
    output logic        trans_pkt_end,
    output logic [7:0]  trans_pkt_dat,
    output logic        trans_pkt_err,
    output logic        hdr_err
);

    ip_parse_state_t state, state_nxt;

    logic [5:0]  hdr_cnt;
    logic [3:0]  ver;
    logic [3:0]  ihl;
    logic [15:0] tot_len;
    logic        mf;
    logic [12:0] frag;
    logic [7:0]  prot;
    logic [31:0] src_sr;
    logic [31:0] dst_sr;
    logic [15:0] pay_cnt;
    logic [15:0] pay_len;
    logic [15:0] csum_sum;

    logic        byte_v, st, nd, is_ip;
    logic [3:0]  ihl_eff;
    logic [5:0]  hdr_len;
    logic [15:0] hdr_bytes;
    logic [15:0] pay_len_c;
    logic [15:0] csum_fin;
    logic [31:0] dst_cmp;
    logic        hdr_last, pay_last;
    logic        csum_ok, dst_ok, accept;
    logic        hdr_err_nxt;

    ip_csum16 u_csum (
        .clk   (rx_clk),
        .rst_n (rst_n),
        .clr   (st),
        .en    (st || (state == HDR && byte_v)),
        .dat   (ip_pkt_dat),
        .sum   (csum_sum)
    );

    always_comb begin
        byte_v = ip_pkt_en;
        st     = byte_v && ip_pkt_start;
        nd     = byte_v && ip_pkt_end;
        is_ip  = (ip_prot_type == ETH_TYPE_IPV4);

        // A short IHL still consumes a minimal header before rejecting.
        ihl_eff   = (ihl < IPV4_MIN_IHL) ? IPV4_MIN_IHL : ihl;
        hdr_len   = {ihl_eff, 2'b00};
        hdr_bytes = {10'd0, ihl, 2'b00};
        pay_len_c = tot_len - hdr_bytes;

        hdr_last = (state == HDR) && byte_v && !st &&
                   (hdr_cnt == hdr_len - 6'd1);
        pay_last = (state == PAYLOAD) && byte_v && !st &&
                   (pay_cnt + 16'd1 == pay_len);

        // The last header byte always sits in the low half of a word.
        csum_fin = csum_add(csum_sum, {8'h00, ip_pkt_dat});
        csum_ok  = !CHK_EN || (csum_fin == 16'hFFFF);

        dst_cmp = (hdr_cnt == 6'd19) ? {dst_sr[23:0], ip_pkt_dat}
                                     : dst_sr;
        dst_ok  = (dst_cmp == local_ip_addr) ||
                  (ACCEPT_BCAST && dst_cmp == 32'hFFFF_FFFF);

        accept = (ver == 4'd4) && (ihl >= IPV4_MIN_IHL) &&
                 (tot_len >= hdr_bytes) && !mf &&
                 (frag == 13'd0) && csum_ok && dst_ok;

        hdr_err_nxt = (hdr_last && !accept) ||
                      ((state == HDR) && nd && !st && !hdr_last) ||
                      (st && nd && is_ip);
    end

    always_comb begin
        state_nxt = state;
        if (st) begin
            state_nxt = nd ? IDLE : (is_ip ? HDR : DROP);
        end else begin
            unique case (state)
                IDLE: state_nxt = IDLE;
                HDR: begin
                    if (hdr_last)
                        state_nxt = nd ? IDLE :
                            ((accept && pay_len_c != 16'd0) ? PAYLOAD : DROP);
                    else if (nd)
                        state_nxt = IDLE;
                end
                PAYLOAD: begin
                    if (pay_last)
                        state_nxt = nd ? IDLE : DROP;
                    else if (nd)
                        state_nxt = IDLE;
                end
                DROP: if (nd) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_cnt         <= 6'd0;
            ver             <= 4'd0;
            ihl             <= 4'd0;
            tot_len         <= 16'd0;
            mf              <= 1'b0;
            frag            <= 13'd0;
            prot            <= 8'd0;
            src_sr          <= 32'd0;
            dst_sr          <= 32'd0;
            pay_cnt         <= 16'd0;
            pay_len         <= 16'd0;
            src_ip_addr     <= 32'd0;
            des_ip_addr     <= 32'd0;
            trans_prot_type <= 8'd0;
            trans_pkt_start <= 1'b0;
            trans_pkt_en    <= 1'b0;
            trans_pkt_end   <= 1'b0;
            trans_pkt_dat   <= 8'h00;
            trans_pkt_err   <= 1'b0;
            hdr_err         <= 1'b0;
        end else begin
            trans_pkt_start <= 1'b0;
            trans_pkt_en    <= 1'b0;
            trans_pkt_end   <= 1'b0;
            trans_pkt_err   <= 1'b0;
            hdr_err         <= hdr_err_nxt;

            if (st) begin
                hdr_cnt <= 6'd1;
                ver     <= ip_pkt_dat[7:4];
                ihl     <= ip_pkt_dat[3:0];
                pay_cnt <= 16'd0;
                if (state == PAYLOAD) begin
                    trans_pkt_end <= 1'b1;
                    trans_pkt_err <= 1'b1;
                end
            end else if (state == HDR && byte_v) begin
                hdr_cnt <= hdr_cnt + 6'd1;
                case (hdr_cnt)
                    6'd2: tot_len[15:8] <= ip_pkt_dat;
                    6'd3: tot_len[7:0]  <= ip_pkt_dat;
                    6'd6: begin
                        mf         <= ip_pkt_dat[5];
                        frag[12:8] <= ip_pkt_dat[4:0];
                    end
                    6'd7: frag[7:0] <= ip_pkt_dat;
                    6'd9: prot      <= ip_pkt_dat;
                    default: ;
                endcase
                if (hdr_cnt >= 6'd12 && hdr_cnt <= 6'd15)
                    src_sr <= {src_sr[23:0], ip_pkt_dat};
                if (hdr_cnt >= 6'd16 && hdr_cnt <= 6'd19)
                    dst_sr <= {dst_sr[23:0], ip_pkt_dat};
                if (hdr_last && accept) begin
                    src_ip_addr     <= src_sr;
                    des_ip_addr     <= dst_cmp;
                    trans_prot_type <= prot;
                    pay_len         <= pay_len_c;
                end
            end else if (state == PAYLOAD && byte_v) begin
                pay_cnt         <= pay_cnt + 16'd1;
                trans_pkt_en    <= 1'b1;
                trans_pkt_dat   <= ip_pkt_dat;
                trans_pkt_start <= (pay_cnt == 16'd0);
                trans_pkt_end   <= pay_last || nd;
                trans_pkt_err   <= nd && !pay_last;
            end
        end
    end

endmodule

// File: tb/tb_ipv4_hdr_parse.sv
// Directed bench for ipv4_hdr_parse; a second instance with
// checksum checking disabled shares the same stimulus.
module tb_ipv4_hdr_parse;

    localparam logic [31:0] LOCAL = 32'hC0A8_00AE;
    localparam logic [31:0] SRC_A = 32'hC0A8_0001;
    localparam logic [31:0] SRC_B = 32'h0A00_0001;
    localparam logic [31:0] SRC_C = 32'hC0A8_0002;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ip_pkt_start = 1'b0;
    logic        ip_pkt_en = 1'b0;
    logic [7:0]  ip_pkt_dat = 8'h00;
    logic        ip_pkt_end = 1'b0;
    logic [15:0] ip_prot_type = 16'h0000;
    logic [31:0] local_ip_addr = LOCAL;

    logic [31:0] src_ip_addr, des_ip_addr;
    logic [7:0]  trans_prot_type, trans_pkt_dat;
    logic        trans_pkt_start, trans_pkt_en, trans_pkt_end;
    logic        trans_pkt_err, hdr_err;

    logic [31:0] src1, des1;
    logic [7:0]  prot1, dat1;
    logic        ts1, ten1, tend1, terr1, herr1;

    ipv4_hdr_parse dut (
        .rx_clk(clk), .rst_n(rst_n),
        .ip_pkt_start(ip_pkt_start), .ip_pkt_en(ip_pkt_en),
        .ip_pkt_dat(ip_pkt_dat), .ip_pkt_end(ip_pkt_end),
        .ip_prot_type(ip_prot_type), .local_ip_addr(local_ip_addr),
        .src_ip_addr(src_ip_addr), .des_ip_addr(des_ip_addr),
        .trans_prot_type(trans_prot_type),
        .trans_pkt_start(trans_pkt_start), .trans_pkt_en(trans_pkt_en),
        .trans_pkt_end(trans_pkt_end), .trans_pkt_dat(trans_pkt_dat),
        .trans_pkt_err(trans_pkt_err), .hdr_err(hdr_err)
    );

    ipv4_hdr_parse #(.CHK_EN(1'b0)) dut_nochk (
        .rx_clk(clk), .rst_n(rst_n),
        .ip_pkt_start(ip_pkt_start), .ip_pkt_en(ip_pkt_en),
        .ip_pkt_dat(ip_pkt_dat), .ip_pkt_end(ip_pkt_end),
        .ip_prot_type(ip_prot_type), .local_ip_addr(local_ip_addr),
        .src_ip_addr(src1), .des_ip_addr(des1),
        .trans_prot_type(prot1),
        .trans_pkt_start(ts1), .trans_pkt_en(ten1),
        .trans_pkt_end(tend1), .trans_pkt_dat(dat1),
        .trans_pkt_err(terr1), .hdr_err(herr1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int mark_cyc = -1;
    int st_cyc = -1;
    int he_cyc = -1;
    int he_n = 0;
    int he1_n = 0;
    int en1_n = 0;
    logic [7:0]  frm [0:127];
    logic [11:0] ev_q [$];

    always @(posedge clk) cyc++;

    // {en, start, end, err, dat} for every cycle with trans activity
    always @(negedge clk) begin
        if (rst_n) begin
            if (trans_pkt_en || trans_pkt_start ||
                trans_pkt_end || trans_pkt_err) begin
                ev_q.push_back({trans_pkt_en, trans_pkt_start,
                                trans_pkt_end, trans_pkt_err,
                                trans_pkt_dat});
                if (trans_pkt_start) st_cyc = cyc;
            end
            if (hdr_err) begin
                he_n++;
                he_cyc = cyc;
            end
            if (ten1) en1_n++;
            if (herr1) he1_n++;
        end
    end

    function automatic int ev_count(input int b);
        int n = 0;
        foreach (ev_q[i]) if (ev_q[i][b]) n++;
        return n;
    endfunction

    task automatic clear_log();
        ev_q.delete();
        he_n = 0;
        he1_n = 0;
        en1_n = 0;
        st_cyc = -1;
        he_cyc = -1;
    endtask

    task automatic build_hdr(input logic [3:0] ihl,
                             input logic [15:0] tl,
                             input logic [7:0] fl6,
                             input logic [31:0] src,
                             input logic [31:0] dst,
                             input logic flip);
        int s;
        logic [15:0] cs;
        frm[0] = {4'h4, ihl};  frm[1] = 8'h00;
        frm[2] = tl[15:8];     frm[3] = tl[7:0];
        frm[4] = 8'h12;        frm[5] = 8'h34;
        frm[6] = fl6;          frm[7] = 8'h00;
        frm[8] = 8'h40;        frm[9] = 8'd17;
        frm[10] = 8'h00;       frm[11] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            frm[12+i] = src[31-8*i -: 8];
            frm[16+i] = dst[31-8*i -: 8];
        end
        for (int i = 20; i < int'(ihl) * 4; i++) frm[i] = 8'h01;
        s = 0;
        for (int w = 0; w < int'(ihl) * 2; w++) begin
            s = s + int'({frm[2*w], frm[2*w+1]});
            s = (s & 32'hFFFF) + (s >> 16);
        end
        cs = ~s[15:0];
        frm[10] = cs[15:8];
        frm[11] = cs[7:0] ^ {7'd0, flip};
    endtask

    task automatic fill(input int off, input int n, input logic [7:0] v0,
                        input bit ramp);
        for (int i = 0; i < n; i++)
            frm[off+i] = ramp ? v0 + 8'(i) : v0;
    endtask

    task automatic send_frame(input int from, input int len,
                              input bit gaps, input bit do_end,
                              input logic [15:0] et, input int mark);
        ip_prot_type = et;
        for (int i = from; i < len; i++) begin
            @(posedge clk); #1;
            ip_pkt_en    = 1'b1;
            ip_pkt_dat   = frm[i];
            ip_pkt_start = (i == 0);
            ip_pkt_end   = do_end && (i == len - 1);
            if (i == mark) mark_cyc = cyc;
            if (gaps && (i % 3 == 2)) begin
                @(posedge clk); #1;
                ip_pkt_en = 1'b0;
                ip_pkt_start = 1'b0;
                ip_pkt_end = 1'b0;
            end
        end
        @(posedge clk); #1;
        ip_pkt_en = 1'b0;
        ip_pkt_start = 1'b0;
        ip_pkt_end = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (src_ip_addr !== 32'h0 || des_ip_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h/%h expected 0/0",
                     src_ip_addr, des_ip_addr);
        end
        n_checks++;
        if (trans_prot_type !== 8'h0 || trans_pkt_dat !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_prot_dat: got %h/%h expected 00/00",
                     trans_prot_type, trans_pkt_dat);
        end
        n_checks++;
        if ({trans_pkt_start, trans_pkt_en, trans_pkt_end,
             trans_pkt_err, hdr_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {trans_pkt_start, trans_pkt_en, trans_pkt_end,
                      trans_pkt_err, hdr_err});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_valid_udp();
        int bad = 0;
        clear_log();
        build_hdr(4'd7, 16'd48, 8'h00, SRC_A, LOCAL, 1'b0);
        fill(28, 20, 8'h00, 1'b1);
        send_frame(0, 48, 1'b0, 1'b1, 16'h0800, 28);
        n_checks++;
        if (ev_q.size() != 20 || ev_count(11) != 20) begin
            n_fail++;
            $display("FAIL udp_count: got %0d events %0d en expected 20/20",
                     ev_q.size(), ev_count(11));
        end
        n_checks++;
        if (ev_q[0] !== {4'b1100, 8'h00}) begin
            n_fail++;
            $display("FAIL udp_first: got %h expected c00", ev_q[0]);
        end
        n_checks++;
        if (ev_q[19] !== {4'b1010, 8'h13}) begin
            n_fail++;
            $display("FAIL udp_last: got %h expected a13", ev_q[19]);
        end
        foreach (ev_q[i]) if (ev_q[i][7:0] !== 8'(i)) bad++;
        n_checks++;
        if (bad != 0 || ev_count(8) != 0 || ev_count(10) != 1) begin
            n_fail++;
            $display("FAIL udp_data: got %0d bad %0d err %0d start expected 0/0/1",
                     bad, ev_count(8), ev_count(10));
        end
        n_checks++;
        if (st_cyc != mark_cyc + 1) begin
            n_fail++;
            $display("FAIL udp_latency: got cycle %0d expected %0d",
                     st_cyc, mark_cyc + 1);
        end
        n_checks++;
        if (trans_prot_type !== 8'd17 || src_ip_addr !== SRC_A ||
            des_ip_addr !== LOCAL) begin
            n_fail++;
            $display("FAIL udp_fields: got %h %h %h expected 11 %h %h",
                     trans_prot_type, src_ip_addr, des_ip_addr,
                     SRC_A, LOCAL);
        end
        n_checks++;
        if (he_n != 0) begin
            n_fail++;
            $display("FAIL udp_hdr_err: got %0d expected 0", he_n);
        end
    endtask

    task automatic test_bad_csum();
        clear_log();
        build_hdr(4'd7, 16'd48, 8'h00, SRC_B, LOCAL, 1'b1);
        fill(28, 20, 8'h00, 1'b1);
        send_frame(0, 48, 1'b0, 1'b1, 16'h0800, 27);
        n_checks++;
        if (he_n != 1 || he_cyc != mark_cyc + 1) begin
            n_fail++;
            $display("FAIL csum_hdr_err: got %0d pulses at %0d expected 1 at %0d",
                     he_n, he_cyc, mark_cyc + 1);
        end
        n_checks++;
        if (ev_q.size() != 0 || src_ip_addr !== SRC_A) begin
            n_fail++;
            $display("FAIL csum_reject: got %0d events src %h expected 0 %h",
                     ev_q.size(), src_ip_addr, SRC_A);
        end
        n_checks++;
        if (en1_n != 20 || he1_n != 0 || src1 !== SRC_B) begin
            n_fail++;
            $display("FAIL csum_off_accept: got %0d en %0d err src %h expected 20 0 %h",
                     en1_n, he1_n, src1, SRC_B);
        end
    endtask

    task automatic test_pad();
        clear_log();
        build_hdr(4'd5, 16'd46, 8'h00, SRC_A, LOCAL, 1'b0);
        fill(20, 26, 8'h00, 1'b1);
        fill(46, 18, 8'hEE, 1'b0);
        send_frame(0, 64, 1'b0, 1'b1, 16'h0800, -1);
        n_checks++;
        if (ev_q.size() != 26 || ev_count(9) != 1) begin
            n_fail++;
            $display("FAIL pad_count: got %0d events %0d ends expected 26/1",
                     ev_q.size(), ev_count(9));
        end
        n_checks++;
        if (ev_q[25] !== {4'b1010, 8'h19}) begin
            n_fail++;
            $display("FAIL pad_last: got %h expected a19", ev_q[25]);
        end
        clear_log();
        build_hdr(4'd5, 16'd21, 8'h00, SRC_A, LOCAL, 1'b0);
        fill(20, 1, 8'h5A, 1'b0);
        fill(21, 25, 8'hEE, 1'b0);
        send_frame(0, 46, 1'b0, 1'b1, 16'h0800, -1);
        n_checks++;
        if (ev_q.size() != 1 || ev_q[0] !== {4'b1110, 8'h5A}) begin
            n_fail++;
            $display("FAIL len1: got %0d events first %h expected 1 e5a",
                     ev_q.size(), ev_q[0]);
        end
    endtask

    task automatic test_reject();
        clear_log();
        build_hdr(4'd5, 16'd30, 8'h00, SRC_B, 32'hC0A8_00AF, 1'b0);
        fill(20, 26, 8'h00, 1'b1);
        send_frame(0, 46, 1'b0, 1'b1, 16'h0800, -1);
        n_checks++;
        if (he_n != 1 || ev_q.size() != 0 || src_ip_addr !== SRC_A) begin
            n_fail++;
            $display("FAIL rej_dst: got %0d err %0d events src %h expected 1 0 %h",
                     he_n, ev_q.size(), src_ip_addr, SRC_A);
        end
        clear_log();
        build_hdr(4'd5, 16'd30, 8'h20, SRC_B, LOCAL, 1'b0);
        send_frame(0, 46, 1'b0, 1'b1, 16'h0800, -1);
        n_checks++;
        if (he_n != 1 || ev_q.size() != 0) begin
            n_fail++;
            $display("FAIL rej_mf: got %0d err %0d events expected 1 0",
                     he_n, ev_q.size());
        end
        clear_log();
        build_hdr(4'd5, 16'd30, 8'h00, SRC_B, LOCAL, 1'b0);
        send_frame(0, 46, 1'b0, 1'b1, 16'h0806, -1);
        n_checks++;
        if (he_n != 0 || ev_q.size() != 0 || src_ip_addr !== SRC_A) begin
            n_fail++;
            $display("FAIL rej_arp: got %0d err %0d events src %h expected 0 0 %h",
                     he_n, ev_q.size(), src_ip_addr, SRC_A);
        end
        clear_log();
        build_hdr(4'd5, 16'd30, 8'h00, SRC_C, 32'hFFFF_FFFF, 1'b0);
        send_frame(0, 46, 1'b0, 1'b1, 16'h0800, -1);
        n_checks++;
        if (ev_q.size() != 10 || des_ip_addr !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL bcast: got %0d events des %h expected 10 ffffffff",
                     ev_q.size(), des_ip_addr);
        end
        clear_log();
        build_hdr(4'd5, 16'd20, 8'h00, SRC_B, LOCAL, 1'b0);
        send_frame(0, 46, 1'b0, 1'b1, 16'h0800, -1);
        n_checks++;
        if (ev_q.size() != 0 || he_n != 0 || src_ip_addr !== SRC_B) begin
            n_fail++;
            $display("FAIL len0: got %0d events %0d err src %h expected 0 0 %h",
                     ev_q.size(), he_n, src_ip_addr, SRC_B);
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        build_hdr(4'd5, 16'd30, 8'h00, SRC_A, LOCAL, 1'b0);
        fill(20, 10, 8'h00, 1'b1);
        send_frame(0, 25, 1'b1, 1'b0, 16'h0800, -1);
        build_hdr(4'd5, 16'd24, 8'h00, SRC_C, LOCAL, 1'b0);
        fill(20, 4, 8'h00, 1'b1);
        send_frame(0, 24, 1'b1, 1'b1, 16'h0800, -1);
        n_checks++;
        if (ev_q.size() != 10 || ev_q[0] !== {4'b1100, 8'h00} ||
            ev_q[4] !== {4'b1000, 8'h04}) begin
            n_fail++;
            $display("FAIL abort_first: got %0d events %h %h expected 10 c00 804",
                     ev_q.size(), ev_q[0], ev_q[4]);
        end
        n_checks++;
        if (ev_q[5][11:8] !== 4'b0011) begin
            n_fail++;
            $display("FAIL abort_pulse: got %b expected 0011", ev_q[5][11:8]);
        end
        n_checks++;
        if (ev_q[6] !== {4'b1100, 8'h00} || ev_q[9] !== {4'b1010, 8'h03} ||
            src_ip_addr !== SRC_C || he_n != 0) begin
            n_fail++;
            $display("FAIL abort_second: got %h %h src %h err %0d expected c00 a03 %h 0",
                     ev_q[6], ev_q[9], src_ip_addr, he_n, SRC_C);
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        build_hdr(4'd5, 16'd30, 8'h00, SRC_A, LOCAL, 1'b0);
        fill(20, 10, 8'h00, 1'b1);
        send_frame(0, 25, 1'b0, 1'b0, 16'h0800, -1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (src_ip_addr !== 32'h0 || des_ip_addr !== 32'h0 ||
            trans_prot_type !== 8'h0 || trans_pkt_dat !== 8'h00 ||
            {trans_pkt_start, trans_pkt_en, trans_pkt_end,
             trans_pkt_err, hdr_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h %h %h %h expected all zero",
                     src_ip_addr, des_ip_addr, trans_prot_type, trans_pkt_dat);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_log();
        send_frame(25, 30, 1'b0, 1'b1, 16'h0800, -1);
        n_checks++;
        if (ev_q.size() != 0 || he_n != 0) begin
            n_fail++;
            $display("FAIL midrst_tail: got %0d events %0d err expected 0 0",
                     ev_q.size(), he_n);
        end
        build_hdr(4'd5, 16'd24, 8'h00, SRC_C, LOCAL, 1'b0);
        fill(20, 4, 8'h00, 1'b1);
        send_frame(0, 24, 1'b0, 1'b1, 16'h0800, -1);
        n_checks++;
        if (ev_q.size() != 4 || ev_q[3] !== {4'b1010, 8'h03} ||
            src_ip_addr !== SRC_C) begin
            n_fail++;
            $display("FAIL midrst_next: got %0d events %h src %h expected 4 a03 %h",
                     ev_q.size(), ev_q[3], src_ip_addr, SRC_C);
        end
    endtask

    initial begin
        test_reset();
        test_valid_udp();
        test_bad_csum();
        test_pad();
        test_reject();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
